// File: rtl/exe_div_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// exe_div_sequencer_pkg
//   Shared execute-stage definitions. This file holds the exe_fun encodings
//   used by EX, including the RV32M divide/remainder codes, plus small
//   decode helpers for the divide sequencer.
//   No ports (package). Related build option: DIV_RESULT_CACHE_EN (used by
//   exe_div_sequencer).
// ----------------------------------------------------------------------------
package exe_div_sequencer_pkg;

    localparam int EXE_FUN_W = 5;

    // Existing single-cycle ALU operations
    localparam logic [EXE_FUN_W-1:0] ALU_X    = 5'd0;
    localparam logic [EXE_FUN_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [EXE_FUN_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [EXE_FUN_W-1:0] ALU_AND  = 5'd3;
    localparam logic [EXE_FUN_W-1:0] ALU_OR   = 5'd4;
    localparam logic [EXE_FUN_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [EXE_FUN_W-1:0] ALU_SLL  = 5'd6;
    localparam logic [EXE_FUN_W-1:0] ALU_SRL  = 5'd7;
    localparam logic [EXE_FUN_W-1:0] ALU_SRA  = 5'd8;
    localparam logic [EXE_FUN_W-1:0] ALU_SLT  = 5'd9;
    localparam logic [EXE_FUN_W-1:0] ALU_SLTU = 5'd10;

    // Multi-cycle RV32M divide operations
    localparam logic [EXE_FUN_W-1:0] ALU_DIV  = 5'd19;
    localparam logic [EXE_FUN_W-1:0] ALU_DIVU = 5'd20;
    localparam logic [EXE_FUN_W-1:0] ALU_REM  = 5'd21;
    localparam logic [EXE_FUN_W-1:0] ALU_REMU = 5'd22;

    function automatic logic is_div_fun(input logic [EXE_FUN_W-1:0] fun);
        return (fun == ALU_DIV) || (fun == ALU_DIVU) ||
               (fun == ALU_REM) || (fun == ALU_REMU);
    endfunction

    function automatic logic is_signed_div_fun(input logic [EXE_FUN_W-1:0] fun);
        return (fun == ALU_DIV) || (fun == ALU_REM);
    endfunction

    function automatic logic is_rem_fun(input logic [EXE_FUN_W-1:0] fun);
        return (fun == ALU_REM) || (fun == ALU_REMU);
    endfunction

endpackage

// File: rtl/exe_div_sequencer_core.sv
// ----------------------------------------------------------------------------
// div_core_serial
//   Unsigned restoring divider, one quotient bit per step. After XLEN steps
//   following a load, quotient/remainder hold dividend/divisor results.
//   Ports:
//     clk, rst             clock, async active-high reset
//     load                 capture dividend/divisor, clear partial remainder
//     step                 perform one shift-subtract iteration
//     dividend, divisor    unsigned operands (sampled on load)
//     quotient, remainder  results; while step is high they show the value
//                          after the current step, so the caller can latch
//                          the final result on the edge of the last step
// ----------------------------------------------------------------------------
module div_core_serial #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] div_q;

    logic [XLEN:0]   partial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] rem_nx;

    // The partial remainder is one bit wider than the operands so the
    // subtract borrow lands in the top bit. The dividend shifts out of the
    // quotient register MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        partial = {rem_q, quo_q[XLEN-1]};
        diff    = partial - {1'b0, div_q};
        if (diff[XLEN]) begin
            rem_nx = partial[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

    assign quotient  = step ? quo_nx : quo_q;
    assign remainder = step ? rem_nx : rem_q;

endmodule

// File: rtl/exe_div_sequencer.sv
// ----------------------------------------------------------------------------
// exe_div_sequencer
//   Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU in the execute stage.
//   Stalls EX while the serial divider runs and returns one registered result.
//   Division by zero and signed overflow are resolved in one cycle.
//   Build option: DIV_RESULT_CACHE_EN keeps the last completed operand pair
//   with both quotient and remainder so a matching follow-up op (e.g. REM
//   after DIV) completes in one cycle.
//   Ports:
//     clk, rst      clock, async active-high reset
//     flush         kill from WB; aborts any op in flight
//     req_valid     EX presents an op this cycle
//     req_fun       exe_fun code; only divide codes are accepted
//     req_op1/2     dividend / divisor
//     stall_flg     hold EX (combinational)
//     res_valid     one-cycle result pulse
//     res_data      quotient or remainder, held until the next result
// ----------------------------------------------------------------------------
module exe_div_sequencer
    import exe_div_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    input  logic [EXE_FUN_W-1:0] req_fun,
    input  logic [XLEN-1:0]      req_op1,
    input  logic [XLEN-1:0]      req_op2,
    output logic                 stall_flg,
    output logic                 res_valid,
    output logic [XLEN-1:0]      res_data
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state;
    logic [CW-1:0]   counter;
    logic            fun_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            is_div;
    logic            is_signed_req;
    logic            is_rem_req;
    logic            accept;
    logic            div_by_zero;
    logic            overflow;
    logic            cache_hit;
    logic            special;
    logic            finishing;
    logic            core_load;
    logic            core_step;
    logic [XLEN-1:0] abs_op1;
    logic [XLEN-1:0] abs_op2;
    logic [XLEN-1:0] cache_data;
    logic [XLEN-1:0] special_data;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;
    logic [XLEN-1:0] fixed_quo;
    logic [XLEN-1:0] fixed_rem;

    // Request decode and the one-cycle special cases. Special cases take
    // precedence over a cache hit; the cache only ever holds ordinary results.
    always_comb begin
        is_div        = is_div_fun(req_fun);
        is_signed_req = is_signed_div_fun(req_fun);
        is_rem_req    = is_rem_fun(req_fun);
        accept        = req_valid & is_div & ~flush & (state != BUSY);
        div_by_zero   = (req_op2 == '0);
        overflow      = is_signed_req & (req_op1 == MIN_NEG) & (req_op2 == '1);
        special       = div_by_zero | overflow | cache_hit;
        abs_op1       = (is_signed_req & req_op1[XLEN-1]) ? -req_op1 : req_op1;
        abs_op2       = (is_signed_req & req_op2[XLEN-1]) ? -req_op2 : req_op2;

        if (div_by_zero) begin
            special_data = is_rem_req ? req_op1 : '1;
        end else if (overflow) begin
            special_data = is_rem_req ? '0 : MIN_NEG;
        end else begin
            special_data = cache_data;
        end
    end

    // Flush drops the stall in the same cycle so EX can be killed cleanly.
    always_comb begin
        stall_flg = ~flush & ((state == BUSY) | (req_valid & is_div));
        core_load = accept & ~special;
        core_step = (state == BUSY);
        finishing = (state == BUSY) & ~flush & (counter == CW'(1));
        fixed_quo = neg_quo_q ? -core_quo : core_quo;
        fixed_rem = neg_rem_q ? -core_rem : core_rem;
    end

    div_core_serial #(
        .XLEN      (XLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (abs_op1),
        .divisor   (abs_op2),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid;
    logic            cache_signed;
    logic [XLEN-1:0] cache_op1;
    logic [XLEN-1:0] cache_op2;
    logic [XLEN-1:0] cache_quo;
    logic [XLEN-1:0] cache_rem;
    logic            key_signed_q;
    logic [XLEN-1:0] key_op1_q;
    logic [XLEN-1:0] key_op2_q;

    // DIV and REM share a key (both signed), as do DIVU and REMU.
    always_comb begin
        cache_hit  = cache_valid & (cache_op1 == req_op1) &
                     (cache_op2 == req_op2) & (cache_signed == is_signed_req);
        cache_data = is_rem_req ? cache_rem : cache_quo;
    end

    // The key is captured at load but the entry is only written when the op
    // actually completes, so a flushed op leaves the previous entry intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_op1    <= '0;
            cache_op2    <= '0;
            cache_quo    <= '0;
            cache_rem    <= '0;
            key_signed_q <= 1'b0;
            key_op1_q    <= '0;
            key_op2_q    <= '0;
        end else begin
            if (core_load) begin
                key_signed_q <= is_signed_req;
                key_op1_q    <= req_op1;
                key_op2_q    <= req_op2;
            end
            if (finishing) begin
                cache_valid  <= 1'b1;
                cache_signed <= key_signed_q;
                cache_op1    <= key_op1_q;
                cache_op2    <= key_op2_q;
                cache_quo    <= fixed_quo;
                cache_rem    <= fixed_rem;
            end
        end
    end
`else
    always_comb begin
        cache_hit  = 1'b0;
        cache_data = '0;
    end
`endif

    // Control FSM. res_valid is registered and asserted for the single cycle
    // spent in DONE; res_data is only rewritten when a new result arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            fun_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                BUSY: begin
                    if (flush) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (counter == CW'(1)) begin
                        state     <= DONE;
                        counter   <= '0;
                        res_valid <= 1'b1;
                        res_data  <= fun_rem_q ? fixed_rem : fixed_quo;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: begin
                    if (accept && special) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= special_data;
                    end else if (accept) begin
                        state     <= BUSY;
                        counter   <= CW'(XLEN);
                        fun_rem_q <= is_rem_req;
                        neg_quo_q <= is_signed_req & (req_op1[XLEN-1] ^ req_op2[XLEN-1]);
                        neg_rem_q <= is_signed_req & req_op1[XLEN-1];
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_div_sequencer.sv
// ----------------------------------------------------------------------------
// tb_exe_div_sequencer
//   Self-checking bench for exe_div_sequencer: directed scenarios plus a
//   randomized run checked against an arithmetic reference model. Honours
//   DIV_RESULT_CACHE_EN when predicting latency.
// ----------------------------------------------------------------------------
module tb_exe_div_sequencer;
    import exe_div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [4:0]  req_fun = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        stall_flg;
    logic        res_valid;
    logic [31:0] res_data;

    int errors = 0;
    int checks = 0;

    // Reference cache model: last ordinary completed operand pair
    bit          mc_valid = 1'b0;
    bit          mc_sgn = 1'b0;
    logic [31:0] mc_a = '0;
    logic [31:0] mc_b = '0;

    exe_div_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_fun   (req_fun),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .stall_flg (stall_flg),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    // Plain arithmetic reference for the result value
    function automatic logic [31:0] ref_result(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (fun == ALU_DIV) || (fun == ALU_REM);
        bit rem = (fun == ALU_REM) || (fun == ALU_REMU);
        int sa = a;
        int sb = b;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? a % b : a / b;
    endfunction

    // Predicts value and latency; ordinary ops update the cache model
    task automatic predict(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output int lat);
        bit sgn = (fun == ALU_DIV) || (fun == ALU_REM);
        data = ref_result(fun, a, b);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            lat = 1;
        end else begin
            lat = 33;
`ifdef DIV_RESULT_CACHE_EN
            if (mc_valid && mc_a == a && mc_b == b && mc_sgn == sgn) lat = 1;
`endif
            mc_valid = 1'b1;
            mc_a = a;
            mc_b = b;
            mc_sgn = sgn;
        end
    endtask

    // Presents one op from a negedge and waits (bounded) for res_valid.
    // stalls counts cycles with stall_flg high before the result cycle.
    task automatic run_op(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [31:0] data, output bit seen);
        req_fun = fun;
        req_op1 = a;
        req_op2 = b;
        req_valid = 1'b1;
        #1;
        stalls = stall_flg ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        data = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = i;
                data = res_data;
                seen = 1'b1;
                break;
            end else if (stall_flg) begin
                stalls++;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (stall_flg !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b want=0", stall_flg); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", res_valid); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got=%h want=0", res_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_neg();
        int lat, st, pl;
        logic [31:0] d, pd;
        bit seen;
        predict(ALU_DIV, 32'hFFFF_FFF9, 32'd2, pd, pl);
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat, st, d, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL div_neg_timeout got=none want=res_valid"); end
        checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_neg_data got=%h want=fffffffd", d); end
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL div_neg_latency got=%0d want=33", lat); end
        checks++; if (st !== 33) begin errors++; $display("[TB] FAIL div_neg_stall got=%0d want=33", st); end
        @(negedge clk);
        predict(ALU_REM, 32'hFFFF_FFF9, 32'd2, pd, pl);
        run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, lat, st, d, seen);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_neg_data got=%h want=ffffffff", d); end
        checks++; if (lat !== pl) begin errors++; $display("[TB] FAIL rem_neg_latency got=%0d want=%0d", lat, pl); end
        // Result must hold while idle, with no further pulse
        repeat (3) @(negedge clk);
        checks++; if (res_data !== 32'hFFFF_FFFF || res_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_data got=%h/%b want=ffffffff/0", res_data, res_valid); end
    endtask

    task automatic test_div_zero();
        int lat, st, pl;
        logic [31:0] d, pd;
        bit seen;
        predict(ALU_DIVU, 32'd100, 32'd0, pd, pl);
        run_op(ALU_DIVU, 32'd100, 32'd0, lat, st, d, seen);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_zero_data got=%h want=ffffffff", d); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL divu_zero_latency got=%0d want=1", lat); end
        @(negedge clk);
        predict(ALU_REM, 32'd5, 32'd0, pd, pl);
        run_op(ALU_REM, 32'd5, 32'd0, lat, st, d, seen);
        checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL rem_zero_data got=%h want=5", d); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL rem_zero_latency got=%0d want=1", lat); end
        checks++; if (st !== 1) begin errors++; $display("[TB] FAIL rem_zero_stall got=%0d want=1", st); end
        #1;
        checks++; if (stall_flg !== 1'b0) begin errors++; $display("[TB] FAIL done_stall got=%b want=0", stall_flg); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lat, st, pl;
        logic [31:0] d, pd;
        bit seen;
        predict(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, pd, pl);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, d, seen);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_div_data got=%h want=80000000", d); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL ovf_div_latency got=%0d want=1", lat); end
        @(negedge clk);
        predict(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, pd, pl);
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, d, seen);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL ovf_rem_data got=%h want=0", d); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL ovf_rem_latency got=%0d want=1", lat); end
        @(negedge clk);
    endtask

    task automatic test_non_div();
        bit pulsed = 1'b0;
        req_fun = ALU_ADD;
        req_op1 = 32'd9;
        req_op2 = 32'd3;
        req_valid = 1'b1;
        #1;
        checks++; if (stall_flg !== 1'b0) begin errors++; $display("[TB] FAIL nondiv_stall got=%b want=0", stall_flg); end
        repeat (4) begin
            @(negedge clk);
            if (res_valid) pulsed = 1'b1;
        end
        checks++; if (pulsed !== 1'b0) begin errors++; $display("[TB] FAIL nondiv_valid got=%b want=0", pulsed); end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        bit pulsed = 1'b0;
        prev = res_data;
        req_fun = ALU_DIVU;
        req_op1 = 32'hFFFF_FFFF;
        req_op2 = 32'd3;
        req_valid = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (stall_flg !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_stall got=%b want=1", stall_flg); end
        flush = 1'b1;
        #1;
        checks++; if (stall_flg !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got=%b want=0", stall_flg); end
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) pulsed = 1'b1;
        end
        checks++; if (pulsed !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b want=0", pulsed); end
        checks++; if (res_data !== prev) begin errors++; $display("[TB] FAIL flush_data got=%h want=%h", res_data, prev); end
        checks++; if (stall_flg !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_stall got=%b want=0", stall_flg); end
    endtask

    task automatic test_reset_mid();
        int lat, st, pl;
        logic [31:0] d, pd;
        bit seen;
        req_fun = ALU_DIVU;
        req_op1 = 32'd1000;
        req_op2 = 32'd7;
        req_valid = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++; if (res_data !== 32'd0 || res_valid !== 1'b0 || stall_flg !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_outputs got=%h/%b/%b want=0/0/0", res_data, res_valid, stall_flg); end
        @(negedge clk);
        rst = 1'b0;
        mc_valid = 1'b0;
        @(negedge clk);
        predict(ALU_REMU, 32'd17, 32'd5, pd, pl);
        run_op(ALU_REMU, 32'd17, 32'd5, lat, st, d, seen);
        checks++; if (d !== 32'd2) begin errors++; $display("[TB] FAIL remu_after_rst_data got=%h want=2", d); end
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL remu_after_rst_latency got=%0d want=33", lat); end
        @(negedge clk);
    endtask

    task automatic test_cache();
        int lat, st, pl, want_lat;
        logic [31:0] d, pd;
        bit seen;
        predict(ALU_DIV, 32'd100, 32'd7, pd, pl);
        run_op(ALU_DIV, 32'd100, 32'd7, lat, st, d, seen);
        checks++; if (d !== 32'd14) begin errors++; $display("[TB] FAIL cache_div_data got=%h want=e", d); end
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL cache_div_latency got=%0d want=33", lat); end
        @(negedge clk);
`ifdef DIV_RESULT_CACHE_EN
        want_lat = 1;
`else
        want_lat = 33;
`endif
        predict(ALU_REM, 32'd100, 32'd7, pd, pl);
        run_op(ALU_REM, 32'd100, 32'd7, lat, st, d, seen);
        checks++; if (d !== 32'd2) begin errors++; $display("[TB] FAIL cache_rem_data got=%h want=2", d); end
        checks++; if (lat !== want_lat) begin errors++; $display("[TB] FAIL cache_rem_latency got=%0d want=%0d", lat, want_lat); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, st, pl;
        logic [31:0] d, pd;
        bit seen;
        predict(ALU_DIVU, 32'd1000, 32'd3, pd, pl);
        run_op(ALU_DIVU, 32'd1000, 32'd3, lat, st, d, seen);
        checks++; if (d !== 32'd333) begin errors++; $display("[TB] FAIL b2b_first_data got=%h want=14d", d); end
        // Next op presented in the DONE cycle, no idle gap
        predict(ALU_REMU, 32'd1000, 32'd3, pd, pl);
        run_op(ALU_REMU, 32'd1000, 32'd3, lat, st, d, seen);
        checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL b2b_second_data got=%h want=1", d); end
        checks++; if (lat !== pl) begin errors++; $display("[TB] FAIL b2b_second_latency got=%0d want=%0d", lat, pl); end
        predict(ALU_DIV, 32'hFFFF_FF9C, 32'd0, pd, pl);
        run_op(ALU_DIV, 32'hFFFF_FF9C, 32'd0, lat, st, d, seen);
        checks++; if (d !== 32'hFFFF_FFFF || lat !== 1) begin
            errors++; $display("[TB] FAIL b2b_special got=%h/%0d want=ffffffff/1", d, lat); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, st, pl;
        logic [31:0] d, pd, a, b;
        logic [4:0] fun;
        bit seen;
        logic [4:0] funs [4];
        funs[0] = ALU_DIV; funs[1] = ALU_DIVU; funs[2] = ALU_REM; funs[3] = ALU_REMU;
        a = 32'd1;
        b = 32'd1;
        for (int n = 0; n < 24; n++) begin
            fun = funs[$urandom_range(0, 3)];
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
                3: ; // reuse previous operands
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            predict(fun, a, b, pd, pl);
            run_op(fun, a, b, lat, st, d, seen);
            checks++; if (d !== pd) begin
                errors++; $display("[TB] FAIL rand_data fun=%0d a=%h b=%h got=%h want=%h", fun, a, b, d, pd); end
            checks++; if (lat !== pl) begin
                errors++; $display("[TB] FAIL rand_latency fun=%0d a=%h b=%h got=%0d want=%0d", fun, a, b, lat, pl); end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_div_neg();
        test_div_zero();
        test_overflow();
        test_non_div();
        test_flush();
        test_reset_mid();
        test_cache();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
